car_motion_controller: RTL and testbench

//  Per-lane car position generator feeding car_x1..car_x8 of the colour/sprite stage.
//  On each frame_tick (1-cycle pulse at start of vertical blanking), steps all 8 lanes sequentially through one shared wrap adder.

---
 rtl/car_motion_controller_pkg.sv | 32 +++
 rtl/car_motion_controller_wrap_adder.sv | 32 +++
 rtl/car_motion_controller.sv | 110 +++++++++++
 tb/tb_car_motion_controller.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/car_motion_controller_pkg.sv
// Shared constants for the lane car motion controller: geometry, start positions,
// lane speeds, lane direction mask and FSM encoding.
package car_motion_controller_pkg;

  localparam int N_LANES = 8;
  localparam int POS_W   = 10;
  localparam int IDX_W   = 3;
  localparam int STEP_W  = 4;
  localparam int LEVEL_W = 3;

  localparam logic [POS_W:0]       H_DISPLAY = 11'd640;
  localparam int                   CAR_WIDTH = 32;
  localparam logic [LEVEL_W-1:0]   MAX_LEVEL = 3'd7;

  localparam logic [POS_W-1:0] START_X [N_LANES] = '{
    10'd0, 10'd80, 10'd160, 10'd240, 10'd320, 10'd400, 10'd480, 10'd560
  };

  localparam logic [STEP_W-1:0] LANE_SPEED [N_LANES] = '{
    4'd1, 4'd2, 4'd1, 4'd3, 4'd2, 4'd1, 4'd3, 4'd2
  };

  // Bit i set means lane i+1 moves left; car_x1, x3, x5, x7 run leftwards.
  localparam logic [N_LANES-1:0] LEFT_MASK = 8'b0101_0101;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_UPDATE = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/car_motion_controller_wrap_adder.sv
// Combinational wrap adder: moves x by step in the given direction, modulo H_DISPLAY.
// Shared by all lanes of car_motion_controller.
module car_motion_controller_wrap_adder
  import car_motion_controller_pkg::*;
(
  input  logic [POS_W-1:0]  x_i,
  input  logic [STEP_W-1:0] step_i,
  input  logic              left_i,
  output logic [POS_W-1:0]  x_o
);

  logic [POS_W:0] x_ext;
  logic [POS_W:0] st_ext;
  logic [POS_W:0] sum_d;

  assign x_ext  = {1'b0, x_i};
  assign st_ext = {{(POS_W + 1 - STEP_W){1'b0}}, step_i};
  assign sum_d  = x_ext + st_ext;

  // Step never exceeds 10, so one conditional correction keeps x in 0..H_DISPLAY-1.
  always_comb begin
    x_o = x_i;
    if (left_i) begin
      if (x_ext < st_ext) x_o = POS_W'(x_ext + H_DISPLAY - st_ext);
      else                x_o = POS_W'(x_ext - st_ext);
    end else begin
      if (sum_d >= H_DISPLAY) x_o = POS_W'(sum_d - H_DISPLAY);
      else                    x_o = POS_W'(sum_d);
    end
  end

endmodule

// File: rtl/car_motion_controller.sv
// Per-frame car position generator: steps 8 lanes through one shared wrap adder into a
// shadow bank, then commits all lanes at once. Optional level support: CAR_MOTION_LEVEL_EN.
module car_motion_controller
  import car_motion_controller_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic               frame_tick,
  input  logic               run,
  input  logic               game_reset,
  input  logic               level_up,
  output logic [POS_W-1:0]   car_x1,
  output logic [POS_W-1:0]   car_x2,
  output logic [POS_W-1:0]   car_x3,
  output logic [POS_W-1:0]   car_x4,
  output logic [POS_W-1:0]   car_x5,
  output logic [POS_W-1:0]   car_x6,
  output logic [POS_W-1:0]   car_x7,
  output logic [POS_W-1:0]   car_x8,
  output logic [LEVEL_W-1:0] level,
  output logic               busy,
  output logic               overrun
);

  state_e             state_q;
  logic [IDX_W-1:0]   idx_q;
  logic [POS_W-1:0]   pos_q    [N_LANES];
  logic [POS_W-1:0]   shadow_q [N_LANES];
  logic               busy_q;
  logic               overrun_q;
  logic [LEVEL_W-1:0] level_q;
  logic [STEP_W-1:0]  step_d;
  logic [POS_W-1:0]   wrap_d;
  logic               clr;

  assign clr = RST | game_reset;

`ifdef CAR_MOTION_LEVEL_EN
  always_ff @(posedge CLK) begin
    if (clr) begin
      level_q <= '0;
    end else if (level_up && (level_q != MAX_LEVEL)) begin
      level_q <= level_q + LEVEL_W'(1);
    end
  end
`else
  logic unused_level_up;
  assign unused_level_up = level_up;
  assign level_q         = '0;
`endif

  assign step_d = LANE_SPEED[idx_q] + STEP_W'(level_q);

  // Lanes always read committed positions, never the partially updated shadow bank.
  car_motion_controller_wrap_adder u_car_wrap_adder (
    .x_i    (pos_q[idx_q]),
    .step_i (step_d),
    .left_i (LEFT_MASK[idx_q]),
    .x_o    (wrap_d)
  );

  always_ff @(posedge CLK) begin
    if (clr) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
        pos_q[i]    <= START_X[i];
        shadow_q[i] <= START_X[i];
      end
    end else begin
      if (frame_tick && busy_q) overrun_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (frame_tick && run) begin
            state_q <= S_UPDATE;
            idx_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
        S_UPDATE: begin
          shadow_q[idx_q] <= wrap_d;
          if (idx_q == IDX_W'(N_LANES - 1)) state_q <= S_COMMIT;
          else                              idx_q   <= idx_q + IDX_W'(1);
        end
        S_COMMIT: begin
          for (int i = 0; i < N_LANES; i++) pos_q[i] <= shadow_q[i];
          busy_q  <= 1'b0;
          idx_q   <= '0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign car_x1  = pos_q[0];
  assign car_x2  = pos_q[1];
  assign car_x3  = pos_q[2];
  assign car_x4  = pos_q[3];
  assign car_x5  = pos_q[4];
  assign car_x6  = pos_q[5];
  assign car_x7  = pos_q[6];
  assign car_x8  = pos_q[7];
  assign level   = level_q;
  assign busy    = busy_q;
  assign overrun = overrun_q;

endmodule

// File: tb/tb_car_motion_controller.sv
// Scoreboard bench for car_motion_controller: accepted ticks push predicted commits,
// a monitor pops and compares on every commit (busy falling edge).
module tb_car_motion_controller;

  logic CLK = 1'b0;
  logic RST = 1'b0, frame_tick = 1'b0, run = 1'b0, game_reset = 1'b0, level_up = 1'b0;
  logic [9:0] cx1, cx2, cx3, cx4, cx5, cx6, cx7, cx8;
  logic [2:0] level;
  logic       busy, overrun;
  logic [7:0][9:0] cur_pos;

  assign cur_pos = {cx8, cx7, cx6, cx5, cx4, cx3, cx2, cx1};

  car_motion_controller dut (
    .CLK(CLK), .RST(RST), .frame_tick(frame_tick), .run(run),
    .game_reset(game_reset), .level_up(level_up),
    .car_x1(cx1), .car_x2(cx2), .car_x3(cx3), .car_x4(cx4),
    .car_x5(cx5), .car_x6(cx6), .car_x7(cx7), .car_x8(cx8),
    .level(level), .busy(busy), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [7:0][9:0] pos;
    int              due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int model_pos [8];
  int model_level = 0;
  bit model_ovr = 1'b0;
  int busy_until = -1;
  localparam int SPEED [8] = '{1, 2, 1, 3, 2, 1, 3, 2};

  // Odd-numbered cars (index 0,2,4,6) drive left, the others right, all modulo 640.
  function automatic int next_x(int x, int lane, int lvl);
    int st;
    st = SPEED[lane] + lvl;
    if (lane % 2 == 0) return (x - st + 640) % 640;
    return (x + st) % 640;
  endfunction

  task automatic chk(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Monitor: a busy falling edge not caused by reset is a commit.
  logic rst_edge = 1'b0;
  logic busy_prev = 1'b0;
  int   busy_start = 0;
  always @(posedge CLK) rst_edge <= RST | game_reset;

  always @(negedge CLK) begin
    if (busy && !busy_prev) busy_start = cyc;
    if (!busy && busy_prev && !rst_edge) begin
      chk("busy_len", cyc - busy_start, 9);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit: commit at cycle %0d with no accepted tick", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("commit_cycle", cyc, mon_e.due);
        for (int i = 0; i < 8; i++)
          chk($sformatf("car_x%0d", i + 1), int'(cur_pos[i]), int'(mon_e.pos[i]));
      end
    end else if (sb.size() != 0 && cyc > sb[0].due + 2) begin
      checks++;
      failures++;
      $display("FAIL commit_timeout: got no commit by cycle %0d, expected at %0d", cyc, sb[0].due);
      void'(sb.pop_front());
    end
    busy_prev = busy;
  end

  task automatic wait_cycles(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic tick();
    exp_t e;
    frame_tick = 1'b1;
    @(posedge CLK);
    #1;
    frame_tick = 1'b0;
    if (cyc <= busy_until) begin
      model_ovr = 1'b1;
    end else if (run) begin
      for (int i = 0; i < 8; i++) begin
        model_pos[i] = next_x(model_pos[i], i, model_level);
        e.pos[i] = 10'(model_pos[i]);
      end
      e.due = cyc + 9;
      busy_until = cyc + 9;
      sb.push_back(e);
    end
  endtask

  task automatic pulse_level_up();
    level_up = 1'b1;
    @(posedge CLK);
    #1;
    level_up = 1'b0;
`ifdef CAR_MOTION_LEVEL_EN
    if (model_level < 7) model_level++;
`endif
  endtask

  task automatic check_state(string tag);
    for (int i = 0; i < 8; i++)
      chk($sformatf("%s_car_x%0d", tag, i + 1), int'(cur_pos[i]), model_pos[i]);
    chk({tag, "_level"}, int'(level), model_level);
    chk({tag, "_overrun"}, int'(overrun), int'(model_ovr));
  endtask

  task automatic pulse_reset(bit game, string tag);
    if (game) game_reset = 1'b1;
    else      RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    game_reset = 1'b0;
    for (int i = 0; i < 8; i++) model_pos[i] = 80 * i;
    model_level = 0;
    model_ovr = 1'b0;
    busy_until = -1;
    sb.delete();
    check_state(tag);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int guard;
    wait_cycles(2);

    pulse_reset(1'b0, "rst");

    run = 1'b1;
    tick();
    wait_cycles(10);
    chk("first_car_x1", int'(cx1), 639);
    chk("first_car_x2", int'(cx2), 82);
    chk("first_car_x4", int'(cx4), 243);

    guard = 0;
    while (model_pos[1] != 638 && guard < 400) begin
      tick();
      wait_cycles($urandom_range(10, 16));
      guard++;
    end
    chk("pre_wrap_car_x2", int'(cx2), 638);
    tick();
    wait_cycles(10);
    chk("right_wrap_car_x2", int'(cx2), 0);

    tick();
    wait_cycles(2);
    tick();
    wait_cycles(12);
    chk("overrun_set", int'(overrun), 1);
    check_state("ovr");
    pulse_reset(1'b1, "greset");

    repeat (9) pulse_level_up();
`ifdef CAR_MOTION_LEVEL_EN
    chk("level_sat", int'(level), 7);
`else
    chk("level_tied", int'(level), 0);
`endif
    tick();
    wait_cycles(10);
`ifdef CAR_MOTION_LEVEL_EN
    chk("lvl_car_x2", int'(cx2), 89);
    chk("lvl_car_x1", int'(cx1), 632);
`else
    chk("nolvl_car_x2", int'(cx2), 82);
`endif
    pulse_reset(1'b1, "lvl_reset");

    tick();
    wait_cycles(3);
    pulse_reset(1'b1, "abort");
    wait_cycles(12);
    check_state("post_abort");
    run = 1'b0;
    tick();
    for (int k = 0; k < 10; k++) begin
      chk("run0_busy", int'(busy), 0);
      wait_cycles(1);
    end
    check_state("run0");

    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 2 && cyc + 1 > busy_until) pulse_level_up();
      run = ($urandom_range(0, 4) != 0);
      tick();
      wait_cycles($urandom_range(1, 14));
    end
    run = 1'b1;
    wait_cycles(20);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
